// File: rtl/srg_program_loader.sv
// Loader that turns 32-bit instruction words into four big-endian byte writes
// on consecutive addresses of a byte-write / word-read program memory.
module srg_program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          MEM_BYTES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  input  logic        word_last,
  output logic        word_ready,
  output logic        mem_write_readn,
  output logic [31:0] mem_address,
  output logic [7:0]  mem_write_data,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [7:0]  word_count
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WAIT = 3'd1;
  localparam logic [2:0] B0   = 3'd2;
  localparam logic [2:0] B1   = 3'd3;
  localparam logic [2:0] B2   = 3'd4;
  localparam logic [2:0] B3   = 3'd5;
  localparam logic [2:0] DONE = 3'd6;

  // Highest address at which a whole word still fits in the memory.
  localparam logic [31:0] LAST_WORD_ADDR = 32'(MEM_BYTES - 4);

  logic [2:0]  state;
  logic [31:0] addr;
  logic [31:0] wordReg;
  logic        lastReg;

  logic addrFits;
  assign addrFits   = (addr <= LAST_WORD_ADDR);
  assign word_ready = (state == WAIT) && addrFits;

  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; mixing in = would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      addr            <= 32'd0;
      wordReg         <= 32'd0;
      lastReg         <= 1'b0;
      mem_write_readn <= 1'b0;
      mem_address     <= 32'd0;
      mem_write_data  <= 8'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
      overflow        <= 1'b0;
      word_count      <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          mem_write_readn <= 1'b0;
          if (start) begin
            addr       <= BASE_ADDR;
            word_count <= 8'd0;
            overflow   <= 1'b0;
            busy       <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (!addrFits) begin
            overflow <= 1'b1;
            done     <= 1'b1;
            state    <= DONE;
          end else if (word_valid) begin
            // Outputs are registered, so the B0 byte is loaded on the handshake edge.
            wordReg         <= word_data;
            lastReg         <= word_last;
            mem_write_readn <= 1'b1;
            mem_address     <= addr;
            mem_write_data  <= word_data[31:24];
            state           <= B0;
          end
        end
        B0: begin
          mem_address    <= addr + 32'd1;
          mem_write_data <= wordReg[23:16];
          state          <= B1;
        end
        B1: begin
          mem_address    <= addr + 32'd2;
          mem_write_data <= wordReg[15:8];
          state          <= B2;
        end
        B2: begin
          mem_address    <= addr + 32'd3;
          mem_write_data <= wordReg[7:0];
          state          <= B3;
        end
        B3: begin
          mem_write_readn <= 1'b0;
          addr            <= addr + 32'd4;
          if (word_count != 8'hFF) word_count <= word_count + 8'd1;
          if (lastReg) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= WAIT;
          end
        end
        DONE: begin
          mem_write_readn <= 1'b0;
          busy            <= 1'b0;
          state           <= IDLE;
        end
        default: begin
          mem_write_readn <= 1'b0;
          state           <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_srg_program_loader.sv
// Self-checking bench for srg_program_loader: table-driven single-word sessions
// plus hand sequences, with a scoreboard of expected byte writes.
module tb_srg_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_last;
  logic        word_ready;
  logic        mem_write_readn;
  logic [31:0] mem_address;
  logic [7:0]  mem_write_data;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [7:0]  word_count;

  srg_program_loader #(.BASE_ADDR(32'd0), .MEM_BYTES(8)) dut (
    .clk(clk), .rst(rst), .start(start), .word_valid(word_valid),
    .word_data(word_data), .word_last(word_last), .word_ready(word_ready),
    .mem_write_readn(mem_write_readn), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .busy(busy), .done(done),
    .overflow(overflow), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic [31:0] word;
    logic [7:0]  b0, b1, b2, b3;
  } vec_t;

  wr_t         sb[$];
  logic [7:0]  modelMem [0:7];
  int          vecCount  = 0;
  int          missCount = 0;
  int          cyc       = 0;
  logic [31:0] expAddr;
  int          hsCycle;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vecCount++;
    missCount++;
    $display("FAIL %s: event did not happen within its cycle budget (t=%0t)", name, $time);
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected byte.
  always @(negedge clk) begin
    if (mem_write_readn === 1'b1) begin
      if (sb.size() == 0) begin
        fail_now("unexpected_write");
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("write_addr", mem_address, e.addr);
        check("write_data", {24'd0, mem_write_data}, {24'd0, e.data});
        if (mem_address < 32'd8) modelMem[mem_address[2:0]] = mem_write_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session();
    start = 1'b1;
    tick();
    start = 1'b0;
    expAddr = 32'd0;
  endtask

  // Leaves word_valid high; the caller decides when to drop it.
  task automatic send_word(input logic [31:0] w, input logic l, input logic [31:0] b);
    word_data  = w;
    word_last  = l;
    word_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (word_ready) begin
        for (int k = 0; k < 4; k++) sb.push_back('{expAddr + 32'(k), b[31-8*k -: 8]});
        expAddr += 32'd4;
        hsCycle = cyc;
        tick();
        return;
      end
      tick();
    end
    fail_now("word_accept");
  endtask

  task automatic wait_done(output int readySeen);
    readySeen = 0;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        tick();
        check("done_one_cycle", {31'd0, done}, 32'd0);
        return;
      end
      if (word_ready) readySeen++;
      tick();
    end
    fail_now("done_pulse");
  endtask

  vec_t vecs[3];
  int   rdy;
  int   hs1;

  initial begin
    vecs[0] = '{32'h8C220004, 8'h8C, 8'h22, 8'h00, 8'h04};
    vecs[1] = '{32'hCAFEF00D, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    vecs[2] = '{32'h00FF0180, 8'h00, 8'hFF, 8'h01, 8'h80};

    rst = 1'b1; start = 1'b0; word_valid = 1'b0; word_data = 32'd0; word_last = 1'b0;
    tick();
    tick();
    check("rst_word_ready", {31'd0, word_ready}, 32'd0);
    check("rst_wr", {31'd0, mem_write_readn}, 32'd0);
    check("rst_addr", mem_address, 32'd0);
    check("rst_data", {24'd0, mem_write_data}, 32'd0);
    check("rst_busy_done_ovf", {29'd0, busy, done, overflow}, 32'd0);
    check("rst_count", {24'd0, word_count}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_read_mode", {30'd0, mem_write_readn, busy}, 32'd0);
    end

    // Table: one-word sessions, each must read back as the original word.
    for (int v = 0; v < 3; v++) begin
      start_session();
      check("busy_after_start", {31'd0, busy}, 32'd1);
      send_word(vecs[v].word, 1'b1, {vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3});
      word_valid = 1'b0;
      wait_done(rdy);
      check("single_count", {24'd0, word_count}, 32'd1);
      check("single_overflow", {31'd0, overflow}, 32'd0);
      check("single_read_mode", {31'd0, mem_write_readn}, 32'd0);
      check("single_busy_clear", {31'd0, busy}, 32'd0);
      check("word_readback", {modelMem[0], modelMem[1], modelMem[2], modelMem[3]}, vecs[v].word);
    end

    // Two words back-to-back with valid held high.
    start_session();
    send_word(32'h11223344, 1'b0, 32'h11223344);
    hs1 = hsCycle;
    send_word(32'hAABBCCDD, 1'b1, 32'hAABBCCDD);
    check("handshake_spacing", 32'(hsCycle - hs1), 32'd5);
    word_valid = 1'b0;
    wait_done(rdy);
    check("b2b_count", {24'd0, word_count}, 32'd2);
    check("b2b_overflow", {31'd0, overflow}, 32'd0);
    check("b2b_word1", {modelMem[4], modelMem[5], modelMem[6], modelMem[7]}, 32'hAABBCCDD);

    // Overflow: third word must never be accepted.
    start_session();
    send_word(32'h01020304, 1'b0, 32'h01020304);
    send_word(32'h05060708, 1'b0, 32'h05060708);
    word_data = 32'h090A0B0C;
    wait_done(rdy);
    word_valid = 1'b0;
    check("ovf_ready_never", 32'(rdy), 32'd0);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check("ovf_count", {24'd0, word_count}, 32'd2);
    check("ovf_busy", {31'd0, busy}, 32'd0);
    tick();
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset during B1: the remaining bytes must never be written.
    start_session();
    send_word(32'hDEADBEEF, 1'b1, 32'hDEADBEEF);
    word_valid = 1'b0;
    tick();
    rst = 1'b1;
    #6;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    check("rst_mid_wr", {31'd0, mem_write_readn}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_count", {24'd0, word_count}, 32'd0);
    for (int i = 0; i < 5; i++) tick();

    // start during B2 is ignored; WAIT holds through 7 idle cycles.
    start_session();
    send_word(32'h13579BDF, 1'b0, 32'h13579BDF);
    word_valid = 1'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) begin
      check("wait_hold", {30'd0, word_ready, busy}, 32'd3);
      tick();
    end
    send_word(32'h2468ACE0, 1'b1, 32'h2468ACE0);
    word_valid = 1'b0;
    wait_done(rdy);
    check("robust_count", {24'd0, word_count}, 32'd2);
    check("robust_word1", {modelMem[4], modelMem[5], modelMem[6], modelMem[7]}, 32'h2468ACE0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
